instruction_fetch_unit: RTL and testbench

- Fetch stage upstream of the single-cycle MIPS core datapath (decode/ALU/memory/register stages).
- Owns the program counter and issues word-addressed reads to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned instructions in a small prefetch FIFO and hands {instruction, pc} downstream over a valid/ready handshake.
- Accepts a taken-branch redirect from downstream, which flushes all wrong-path work.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 55 +++++
 rtl/instruction_fetch_unit.sv | 77 +++++++
 tb/tb_instruction_fetch_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// Holds width defaults, the fetch-entry bundle and a NOP encoding.
package fetch_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0;
  localparam logic [31:0] NOP = 32'h0;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [ADDR_W_DEF-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {instruction, pc} entries.
// Flush drops all entries; reset also clears storage.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W = 64,
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign rdata = mem[head];

  // Pointer, occupancy and storage update; flush empties without
  // touching storage.
  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        assert (count != CW'(DEPTH));
        mem[tail] <= wdata;
        tail      <= nxt(tail);
      end
      if (pop) head <= nxt(head);
      if (push && !pop) count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues 1-cycle-latency memory reads and
// buffers returned instructions for a valid/ready consumer.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned UW = CW + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic [CW-1:0]     count;
  logic [UW-1:0]     used;
  logic              pop;
  logic              push;

  assign inst_valid = (count != '0) && !redirect_valid && !reset;
  assign pop        = inst_valid && inst_ready;
  assign push       = inflight && !redirect_valid && !reset;

  // Credits: buffered plus in-flight, less the entry leaving now.
  assign used = {1'b0, count} + UW'(inflight) - UW'(pop);

  assign imem_req  = !reset && !redirect_valid && (used < UW'(DEPTH));
  assign imem_addr = fetch_pc;

  // PC and single outstanding request tracking.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
    end else if (imem_req) begin
      fetch_pc    <= fetch_pc + ADDR_W'(1);
      inflight    <= 1'b1;
      inflight_pc <= fetch_pc;
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (DATA_W + ADDR_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata ({imem_rdata, inflight_pc}),
    .rdata ({inst_data, inst_pc}),
    .count (count)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: cycle table plus delivery
// scoreboards for a RESET_PC=0 and a wrapping RESET_PC instance.
module tb_instruction_fetch_unit;
  import fetch_pkg::*;

  logic        clock;
  logic        reset;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        req1, valid1, req2, valid2;
  logic [31:0] addr1, rdata1, data1, pc1;
  logic [31:0] addr2, rdata2, data2, pc2;

  int total = 0;
  int bad = 0;
  int n1 = 0;
  int n2 = 0;

  fetch_entry_t q1[$];
  fetch_entry_t q2[$];

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          rdv;
    logic [31:0] rpc;
    bit          ereq;
    logic [31:0] eaddr;
    bit          evld;
    logic [31:0] epc;
    bit          z;
  } vec_t;

  vec_t v[$];

  instruction_fetch_unit u_dut1 (
    .clock          (clock),
    .reset          (reset),
    .imem_req       (req1),
    .imem_addr      (addr1),
    .imem_rdata     (rdata1),
    .inst_valid     (valid1),
    .inst_ready     (inst_ready),
    .inst_data      (data1),
    .inst_pc        (pc1),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  instruction_fetch_unit #(
    .RESET_PC (32'hFFFF_FFFE)
  ) u_dut2 (
    .clock          (clock),
    .reset          (reset),
    .imem_req       (req2),
    .imem_addr      (addr2),
    .imem_rdata     (rdata2),
    .inst_valid     (valid2),
    .inst_ready     (inst_ready),
    .inst_data      (data2),
    .inst_pc        (pc2),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Instruction memories: 1-cycle read latency, junk when idle.
  always @(posedge clock) begin
    rdata1 <= req1 ? data_of(addr1) : 32'hDEAD_BEEF;
    rdata2 <= req2 ? data_of(addr2) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic restart(input logic [31:0] s1,
                         input logic [31:0] s2);
    q1.delete();
    q2.delete();
    n1 = 0;
    n2 = 0;
    for (int i = 0; i < 64; i++) begin
      q1.push_back('{data: data_of(s1 + i), pc: s1 + i});
      q2.push_back('{data: data_of(s2 + i), pc: s2 + i});
    end
  endtask

  task automatic deliver(input int id, input logic [31:0] pc,
                         input logic [31:0] d);
    fetch_entry_t e;
    total++;
    if ((id == 1 && q1.size() == 0) ||
        (id == 2 && q2.size() == 0)) begin
      bad++;
      $display("FAIL sb%0d unexpected pc=%h", id, pc);
    end else begin
      e = (id == 1) ? q1.pop_front() : q2.pop_front();
      if (e.pc !== pc || e.data !== d) begin
        bad++;
        $display("FAIL sb%0d pc=%h data=%h exp pc=%h data=%h",
                 id, pc, d, e.pc, e.data);
      end
    end
  endtask

  // Scoreboard side: every accepted instruction is checked in order.
  always @(negedge clock) begin
    if (valid1 === 1'b1 && inst_ready === 1'b1) begin
      deliver(1, pc1, data1);
      n1++;
    end
    if (valid2 === 1'b1 && inst_ready === 1'b1) begin
      deliver(2, pc2, data2);
      n2++;
    end
  end

  function automatic vec_t mk(
    input bit rst, input bit rdy, input bit rdv,
    input logic [31:0] rpc, input bit ereq,
    input logic [31:0] eaddr, input bit evld,
    input logic [31:0] epc, input bit z);
    vec_t r;
    r.rst = rst; r.rdy = rdy; r.rdv = rdv; r.rpc = rpc;
    r.ereq = ereq; r.eaddr = eaddr;
    r.evld = evld; r.epc = epc; r.z = z;
    return r;
  endfunction

  initial begin
    reset = 1'b1;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;

    // streaming from reset, then redirect to 0x40
    v.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 1));
    v.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, 0));
    v.push_back(mk(0, 1, 0, 0, 1, 2, 1, 0, 0));
    v.push_back(mk(0, 1, 0, 0, 1, 3, 1, 1, 0));
    v.push_back(mk(0, 1, 0, 0, 1, 4, 1, 2, 0));
    v.push_back(mk(0, 1, 0, 0, 1, 5, 1, 3, 0));
    v.push_back(mk(0, 1, 1, 'h40, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 1, 0, 0, 1, 'h40, 0, 0, 0));
    v.push_back(mk(0, 1, 0, 0, 1, 'h41, 0, 0, 0));
    v.push_back(mk(0, 1, 0, 0, 1, 'h42, 1, 'h40, 0));
    v.push_back(mk(0, 1, 0, 0, 1, 'h43, 1, 'h41, 0));
    // backpressure from reset, release, refill, full redirect
    v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1));
    v.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
    v.push_back(mk(0, 1, 0, 0, 1, 2, 1, 0, 0));
    v.push_back(mk(0, 1, 0, 0, 1, 3, 1, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2, 0));
    v.push_back(mk(0, 1, 1, 'h100, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 1, 'h100, 0, 0, 0));
    v.push_back(mk(0, 1, 0, 0, 1, 'h101, 0, 0, 0));
    v.push_back(mk(0, 1, 0, 0, 1, 'h102, 1, 'h100, 0));
    // back-to-back redirects: the last one wins
    v.push_back(mk(0, 1, 1, 'h200, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 1, 1, 'h300, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 1, 0, 0, 1, 'h300, 0, 0, 0));
    v.push_back(mk(0, 1, 0, 0, 1, 'h301, 0, 0, 0));
    v.push_back(mk(0, 1, 0, 0, 1, 'h302, 1, 'h300, 0));
    // reset mid-stream with a response in flight
    v.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 1));
    v.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, 0));
    v.push_back(mk(0, 1, 0, 0, 1, 2, 1, 0, 0));
    v.push_back(mk(0, 1, 0, 0, 1, 3, 1, 1, 0));
    v.push_back(mk(0, 1, 0, 0, 1, 4, 1, 2, 0));
    v.push_back(mk(0, 1, 0, 0, 1, 5, 1, 3, 0));

    for (int i = 0; i < v.size(); i++) begin
      @(posedge clock);
      #1;
      reset          = v[i].rst;
      inst_ready     = v[i].rdy;
      redirect_valid = v[i].rdv;
      redirect_pc    = v[i].rpc;
      if (v[i].rst) restart(32'h0, 32'hFFFF_FFFE);
      else if (v[i].rdv) restart(v[i].rpc, v[i].rpc);
      @(negedge clock);
      chk($sformatf("r%0d req", i), 32'(req1), 32'(v[i].ereq));
      if (v[i].ereq)
        chk($sformatf("r%0d addr", i), addr1, v[i].eaddr);
      chk($sformatf("r%0d valid", i), 32'(valid1),
          32'(v[i].evld));
      if (v[i].evld) begin
        chk($sformatf("r%0d pc", i), pc1, v[i].epc);
        chk($sformatf("r%0d data", i), data1,
            data_of(v[i].epc));
      end
      chk($sformatf("r%0d req2", i), 32'(req2), 32'(v[i].ereq));
      chk($sformatf("r%0d valid2", i), 32'(valid2),
          32'(v[i].evld));
      if (v[i].z) begin
        chk($sformatf("r%0d zpc", i), pc1, 32'h0);
        chk($sformatf("r%0d zdata", i), data1, 32'h0);
        chk($sformatf("r%0d zpc2", i), pc2, 32'h0);
        chk($sformatf("r%0d zdata2", i), data2, 32'h0);
      end
    end

    @(posedge clock);
    #1;
    inst_ready = 1'b0;
    @(negedge clock);
    chk("count1", 32'(n1), 32'd4);
    chk("count2", 32'(n2), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
